aes_128_decryptor: RTL

// - Iterative AES-128 inverse cipher (FIPS-197 InvCipher): 128-bit ciphertext + 128-bit key -> plaintext.
// - Receive-side counterpart of aes_128_encryptor; runs one round per clock on a single shared datapath.
// - Expands the key forward into an 11-entry round-key store, then applies rounds 10..0 in reverse.
// - Optional key cache skips the expansion when consecutive requests use the same key.

---
 rtl/aes_128_decryptor.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_128_decryptor.sv
// aes_128_decryptor
//   Iterative AES-128 inverse cipher. One round per clock on a shared
//   datapath. A miss expands the key forward into an 11-entry round-key
//   store before decrypting; a hit reuses the stored round keys.
//
// Ports
//   clk_i      clock, all state on rising edge
//   rst_i      asynchronous active-high reset
//   start_i    request, sampled only while busy_o = 0
//   cipher_i   ciphertext, bits[127:120] = byte 0, column-major
//   key_i      cipher key, same byte order
//   plain_o    registered plaintext, valid while done_o = 1, held until next done
//   busy_o     high from the accepting edge until the done edge
//   done_o     one-cycle pulse, plain_o updated on the same edge
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start_i; hit skips straight to DECRYPT
// KEYEXP  | rk[rcnt] <= KeyExpand(rk[rcnt-1]) for rcnt = 1..10
// DECRYPT | inverse rounds rcnt = 9..1, final round at rcnt = 0
module aes_128_decryptor #(
  parameter int KEY_CACHE = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [127:0] cipher_i,
  input  logic [127:0] key_i,
  output logic [127:0] plain_o,
  output logic         busy_o,
  output logic         done_o
);

  // Byte 0 of the block is the most significant byte.
  typedef logic [0:15][7:0] block_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_KEYEXP,
    ST_DECRYPT
  } state_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul_9(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction

  function automatic logic [7:0] mul_b(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction

  function automatic logic [7:0] mul_d(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction

  function automatic logic [7:0] mul_e(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {mul_e(a0) ^ mul_b(a1) ^ mul_d(a2) ^ mul_9(a3),
            mul_9(a0) ^ mul_e(a1) ^ mul_b(a2) ^ mul_d(a3),
            mul_d(a0) ^ mul_9(a1) ^ mul_e(a2) ^ mul_b(a3),
            mul_b(a0) ^ mul_d(a1) ^ mul_9(a2) ^ mul_e(a3)};
  endfunction

  function automatic block_t inv_mix_columns(input block_t b);
    logic [127:0] v;
    v = b;
    return {inv_mix_col(v[127:96]), inv_mix_col(v[95:64]),
            inv_mix_col(v[63:32]),  inv_mix_col(v[31:0])};
  endfunction

  // Row r rotates right by r positions: out[r][c] = in[r][(c - r) mod 4].
  function automatic block_t inv_shift_rows(input block_t b);
    return {b[0],  b[13], b[10], b[7],
            b[4],  b[1],  b[14], b[11],
            b[8],  b[5],  b[2],  b[15],
            b[12], b[9],  b[6],  b[3]};
  endfunction

  function automatic block_t inv_sub_bytes(input block_t b);
    block_t o;
    for (int i = 0; i < 16; i++) begin
      o[i] = INV_SBOX[b[i]];
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    logic [7:0] r;
    case (n)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] prev,
                                              input logic [7:0]   rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    {w0, w1, w2, w3} = prev;
    // SubWord(RotWord(w3)) ^ Rcon
    t  = {SBOX[w3[23:16]], SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]}
         ^ {rc, 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  state_e       state_q;
  logic [3:0]   rcnt_q;
  block_t       s_q;
  logic [127:0] ct_q;
  logic [127:0] rk_q [0:10];
  logic [127:0] cache_key_q;
  logic         cache_vld_q;
  logic [127:0] plain_q;
  logic         busy_q;
  logic         done_q;

  block_t       isb_d;
  block_t       ark_d;
  block_t       imc_d;
  logic [127:0] kexp_d;
  logic         hit_d;

  // Shared round datapath; the final round takes ark_d directly.
  always_comb begin
    isb_d  = inv_sub_bytes(inv_shift_rows(s_q));
    ark_d  = isb_d ^ rk_q[rcnt_q];
    imc_d  = inv_mix_columns(ark_d);
    kexp_d = key_expand(rk_q[rcnt_q - 4'd1], rcon(rcnt_q));
    hit_d  = (KEY_CACHE != 0) && cache_vld_q && (key_i == cache_key_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      rcnt_q      <= 4'd0;
      s_q         <= '0;
      ct_q        <= '0;
      cache_key_q <= '0;
      cache_vld_q <= 1'b0;
      plain_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i <= 10; i++) begin
        rk_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            busy_q <= 1'b1;
            if (hit_d) begin
              s_q     <= cipher_i ^ rk_q[10];
              rcnt_q  <= 4'd9;
              state_q <= ST_DECRYPT;
            end else begin
              rk_q[0] <= key_i;
              ct_q    <= cipher_i;
              rcnt_q  <= 4'd1;
              state_q <= ST_KEYEXP;
            end
          end
        end
        ST_KEYEXP: begin
          rk_q[rcnt_q] <= kexp_d;
          if (rcnt_q == 4'd10) begin
            // Last round key goes straight into the initial AddRoundKey.
            s_q         <= ct_q ^ kexp_d;
            cache_key_q <= rk_q[0];
            cache_vld_q <= 1'b1;
            rcnt_q      <= 4'd9;
            state_q     <= ST_DECRYPT;
          end else begin
            rcnt_q <= rcnt_q + 4'd1;
          end
        end
        ST_DECRYPT: begin
          if (rcnt_q != 4'd0) begin
            s_q    <= imc_d;
            rcnt_q <= rcnt_q - 4'd1;
          end else begin
            plain_q <= ark_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign plain_o = plain_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule
